// File: rtl/riscv_mul.sv
// Iterative radix-2 shift-add multiplier for the RV M-extension (MUL/MULH/MULHSU/MULHU/MULW).
// Shares the divider's issue/stall/bubble contract; result is a one-cycle mul_bubble=0 pulse.
`ifndef RV32I
`define RV32I 2'b01
`endif

module riscv_mul #(
    parameter int XLEN = 64,
    parameter int ILEN = 64
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            ex_stall,
    output logic            mul_stall,
    input  logic            id_bubble,
    input  logic [ILEN-1:0] id_instr,
    input  logic [XLEN-1:0] opA,
    input  logic [XLEN-1:0] opB,
    input  logic [1:0]      st_xlen,
    output logic            mul_bubble,
    output logic [XLEN-1:0] mul_r
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] LO32 = XLEN'(64'h0000_0000_FFFF_FFFF);

    typedef enum logic [1:0] {
        ST_CHK = 2'b00,
        ST_MUL = 2'b01,
        ST_RES = 2'b10
    } state_t;

    typedef enum logic [2:0] {
        OP_NONE, OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_MULW
    } op_t;

    state_t                 r_state;
    logic [6:0]             r_f7;
    logic [2:0]             r_f3;
    logic [4:0]             r_opc;
    logic [XLEN-1:0]        r_mc;
    logic [XLEN-1:0]        r_mp;
    logic [XLEN-1:0]        r_acc;
    logic                   r_neg;
    logic [CW-1:0]          r_cnt;

    logic [ILEN-1:0]        w_unused_instr;
    op_t                    w_id_op;
    op_t                    w_issue_op;
    logic                   w_mulw_ok;
    logic                   w_issue;
    logic                   w_zero;
    logic [XLEN-1:0]        w_mc;
    logic [XLEN-1:0]        w_mp;
    logic                   w_neg;
    logic [XLEN:0]          w_sum;

    function automatic op_t fn_decode(input logic [6:0] f7, input logic [2:0] f3,
                                      input logic [4:0] opc);
        op_t op;
        op = OP_NONE;
        if (f7 == 7'b0000001) begin
            if (opc == 5'b01100) begin
                case (f3)
                    3'b000:  op = OP_MUL;
                    3'b001:  op = OP_MULH;
                    3'b010:  op = OP_MULHSU;
                    3'b011:  op = OP_MULHU;
                    default: op = OP_NONE;
                endcase
            end else if (opc == 5'b01110 && f3 == 3'b000) begin
                op = OP_MULW;
            end
        end
        return op;
    endfunction

    function automatic logic [XLEN-1:0] fn_abs(input logic [XLEN-1:0] v);
        return v[XLEN-1] ? -v : v;
    endfunction

    // Sign fix-up is applied to the full 2*XLEN product before the high half is taken.
    function automatic logic [XLEN-1:0] fn_result(input op_t op, input logic [XLEN-1:0] acc,
                                                  input logic [XLEN-1:0] mp, input logic neg);
        logic [2*XLEN-1:0] p;
        logic [2*XLEN-1:0] pn;
        p  = {acc, mp};
        pn = neg ? -p : p;
        case (op)
            OP_MUL:             return p[XLEN-1:0];
            OP_MULH, OP_MULHSU: return pn[2*XLEN-1:XLEN];
            OP_MULHU:           return p[2*XLEN-1:XLEN];
            OP_MULW:            return XLEN'($signed(mp[XLEN-1 -: 32]));
            default:            return '0;
        endcase
    endfunction

    assign w_unused_instr = id_instr;
    assign w_id_op    = fn_decode(id_instr[31:25], id_instr[14:12], id_instr[6:2]);
    assign w_mulw_ok  = (st_xlen != `RV32I) && (XLEN == 64);
    assign w_issue_op = (w_id_op == OP_MULW && !w_mulw_ok) ? OP_NONE : w_id_op;
    assign w_issue    = !ex_stall && !id_bubble && (w_issue_op != OP_NONE);
    assign w_zero     = (w_issue_op == OP_MULW) ? (opA[31:0] == 32'd0 || opB[31:0] == 32'd0)
                                                : (opA == '0 || opB == '0);
    assign w_sum      = {1'b0, r_acc} + {1'b0, (r_mp[0] ? r_mc : {XLEN{1'b0}})};

    always_comb begin
        w_mc  = opB;
        w_mp  = opA;
        w_neg = 1'b0;
        case (w_issue_op)
            OP_MULH: begin
                w_mc  = fn_abs(opB);
                w_mp  = fn_abs(opA);
                w_neg = opA[XLEN-1] ^ opB[XLEN-1];
            end
            OP_MULHSU: begin
                w_mp  = fn_abs(opA);
                w_neg = opA[XLEN-1];
            end
            OP_MULW: begin
                w_mc = opB & LO32;
                w_mp = opA & LO32;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= ST_CHK;
            mul_bubble <= 1'b1;
            mul_stall  <= 1'b0;
            mul_r      <= '0;
            r_f7       <= '0;
            r_f3       <= '0;
            r_opc      <= '0;
            r_mc       <= '0;
            r_mp       <= '0;
            r_acc      <= '0;
            r_neg      <= 1'b0;
            r_cnt      <= '0;
        end else begin
            mul_bubble <= 1'b1;
            if (!ex_stall) begin
                r_f7  <= id_instr[31:25];
                r_f3  <= id_instr[14:12];
                r_opc <= id_instr[6:2];
            end
            case (r_state)
                ST_CHK: begin
                    if (w_issue) begin
                        if (w_zero) begin
                            mul_r      <= '0;
                            mul_bubble <= 1'b0;
                        end else begin
                            r_mc      <= w_mc;
                            r_mp      <= w_mp;
                            r_acc     <= '0;
                            r_neg     <= w_neg;
                            r_cnt     <= (w_issue_op == OP_MULW) ? CW'(31) : CW'(XLEN-1);
                            mul_stall <= 1'b1;
                            r_state   <= ST_MUL;
                        end
                    end
                end
                // One multiplier bit per edge; the adder carry lands in acc's MSB.
                ST_MUL: begin
                    {r_acc, r_mp} <= {w_sum, r_mp[XLEN-1:1]};
                    r_cnt         <= r_cnt - 1'b1;
                    if (r_cnt == '0)
                        r_state <= ST_RES;
                end
                ST_RES: begin
                    mul_r      <= fn_result(fn_decode(r_f7, r_f3, r_opc), r_acc, r_mp, r_neg);
                    mul_stall  <= 1'b0;
                    mul_bubble <= 1'b0;
                    r_state    <= ST_CHK;
                end
                default: r_state <= ST_CHK;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_mul.sv
// Directed bench for riscv_mul (XLEN=64): results, latency, stall window, shortcut and reset abort.
`ifndef RV32I
`define RV32I 2'b01
`endif

module tb_riscv_mul;

    logic        clk;
    logic        rstn;
    logic        ex_stall;
    logic        mul_stall;
    logic        id_bubble;
    logic [63:0] id_instr;
    logic [63:0] opA;
    logic [63:0] opB;
    logic [1:0]  st_xlen;
    logic        mul_bubble;
    logic [63:0] mul_r;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] I_MUL    = {7'b0000001, 10'd0, 3'b000, 5'd0, 7'b0110011};
    localparam logic [31:0] I_MULH   = {7'b0000001, 10'd0, 3'b001, 5'd0, 7'b0110011};
    localparam logic [31:0] I_MULHSU = {7'b0000001, 10'd0, 3'b010, 5'd0, 7'b0110011};
    localparam logic [31:0] I_MULHU  = {7'b0000001, 10'd0, 3'b011, 5'd0, 7'b0110011};
    localparam logic [31:0] I_MULW   = {7'b0000001, 10'd0, 3'b000, 5'd0, 7'b0111011};

    riscv_mul #(.XLEN(64), .ILEN(64)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .ex_stall   (ex_stall),
        .mul_stall  (mul_stall),
        .id_bubble  (id_bubble),
        .id_instr   (id_instr),
        .opA        (opA),
        .opB        (opB),
        .st_xlen    (st_xlen),
        .mul_bubble (mul_bubble),
        .mul_r      (mul_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
        end
    endtask

    // Presents one op at the issue edge, then counts cycles until the result pulse.
    task automatic run_op(input logic [31:0] instr, input logic [63:0] a, input logic [63:0] b,
                          input logic bub, input logic stl, input int budget,
                          output int lat, output int stall_n, output logic [63:0] res);
        @(negedge clk);
        id_instr  = {32'd0, instr};
        opA       = a;
        opB       = b;
        id_bubble = bub;
        ex_stall  = stl;
        @(posedge clk);
        #1;
        id_bubble = 1'b1;
        ex_stall  = 1'b0;
        lat       = -1;
        stall_n   = 0;
        res       = '0;
        for (int c = 1; c <= budget; c++) begin
            if (mul_stall) stall_n++;
            if (!mul_bubble) begin
                lat = c;
                res = mul_r;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (lat > 0) begin
            @(posedge clk);
            #1;
            check("pulse_one_cycle", {63'd0, mul_bubble}, 64'd1);
        end
    endtask

    int          lat;
    int          sn;
    logic [63:0] res;

    initial begin
        rstn      = 1'b1;
        ex_stall  = 1'b0;
        id_bubble = 1'b1;
        id_instr  = '0;
        opA       = '0;
        opB       = '0;
        st_xlen   = 2'b10;
        #2 rstn = 1'b0;
        #2;
        check("rst_stall",  {63'd0, mul_stall},  64'd0);
        check("rst_bubble", {63'd0, mul_bubble}, 64'd1);
        check("rst_r",      mul_r,               64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rstn = 1'b1;

        run_op(I_MUL, 64'd7, -64'sd3, 1'b0, 1'b0, 100, lat, sn, res);
        check("mul_res",   res,        64'hFFFF_FFFF_FFFF_FFEB);
        check("mul_lat",   64'(lat),   64'd66);
        check("mul_stall", 64'(sn),    64'd65);

        run_op(I_MULH, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 100, lat, sn, res);
        check("mulh_min_res", res,      64'h4000_0000_0000_0000);
        check("mulh_min_lat", 64'(lat), 64'd66);

        run_op(I_MULH, -64'sd1, 64'd1, 1'b0, 1'b0, 100, lat, sn, res);
        check("mulh_neg_res", res, 64'hFFFF_FFFF_FFFF_FFFF);

        run_op(I_MULHSU, -64'sd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 100, lat, sn, res);
        check("mulhsu_res", res, 64'hFFFF_FFFF_FFFF_FFFF);

        run_op(I_MULHU, -64'sd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 100, lat, sn, res);
        check("mulhu_res", res, 64'hFFFF_FFFF_FFFF_FFFE);

        run_op(I_MULW, 64'h7FFF_FFFF, 64'd2, 1'b0, 1'b0, 100, lat, sn, res);
        check("mulw_res",   res,      64'hFFFF_FFFF_FFFF_FFFE);
        check("mulw_lat",   64'(lat), 64'd34);
        check("mulw_stall", 64'(sn),  64'd33);

        st_xlen = `RV32I;
        run_op(I_MULW, 64'h7FFF_FFFF, 64'd2, 1'b0, 1'b0, 40, lat, sn, res);
        check("mulw_rv32_noresp", 64'(lat), -64'sd1);
        check("mulw_rv32_nostall", 64'(sn), 64'd0);
        st_xlen = 2'b10;

        run_op(I_MUL, 64'd1234, 64'd0, 1'b0, 1'b0, 100, lat, sn, res);
        check("zero_res",   res,      64'd0);
        check("zero_lat",   64'(lat), 64'd1);
        check("zero_stall", 64'(sn),  64'd0);

        run_op(I_MUL, 64'd3, 64'd5, 1'b1, 1'b0, 20, lat, sn, res);
        check("bubble_ignored", 64'(lat), -64'sd1);
        check("bubble_nostall", 64'(sn),  64'd0);

        run_op(I_MUL, 64'd3, 64'd5, 1'b0, 1'b1, 20, lat, sn, res);
        check("exstall_ignored", 64'(lat), -64'sd1);
        check("exstall_nostall", 64'(sn),  64'd0);

        @(negedge clk);
        id_instr  = {32'd0, I_MULHU};
        opA       = 64'hDEAD_BEEF_0000_1234;
        opB       = 64'h0000_0001_0000_0003;
        id_bubble = 1'b0;
        @(posedge clk);
        #1 id_bubble = 1'b1;
        repeat (19) @(posedge clk);
        #1;
        check("abort_stall_before", {63'd0, mul_stall}, 64'd1);
        #1 rstn = 1'b0;
        #1;
        check("abort_stall",  {63'd0, mul_stall},  64'd0);
        check("abort_bubble", {63'd0, mul_bubble}, 64'd1);
        check("abort_r",      mul_r,               64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rstn = 1'b1;

        run_op(I_MUL, 64'd3, 64'd5, 1'b0, 1'b0, 100, lat, sn, res);
        check("post_rst_res", res,      64'd15);
        check("post_rst_lat", 64'(lat), 64'd66);
        check("hold_r",       mul_r,    64'd15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
